// File: rtl/act_pkg.sv
// Shared types and saturation-bound helpers for the activation pipeline.
package act_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_CLIP   = 2'd2,
    MODE_LEAKY  = 2'd3
  } act_mode_e;

  function automatic longint satMaxOf(input int outW);
    return (64'sd1 <<< (outW - 1)) - 64'sd1;
  endfunction

  function automatic longint satMinOf(input int outW);
    return -(64'sd1 <<< (outW - 1));
  endfunction

  localparam int     ACT_OUT_W   = 8;
  localparam longint ACT_SAT_MAX = satMaxOf(ACT_OUT_W);
  localparam longint ACT_SAT_MIN = satMinOf(ACT_OUT_W);

endpackage

// File: rtl/act_lane.sv
// Per-lane combinational activation (stage-1 input) and signed saturation (stage-2 input).
module act_lane
  import act_pkg::*;
#(
  parameter int IN_W    = 32,
  parameter int OUT_W   = ACT_OUT_W,
  parameter int SHIFT_W = 5
) (
  input  act_mode_e                 i_mode,
  input  logic [SHIFT_W-1:0]        i_shift,
  input  logic [IN_W-1:0]           i_clip,
  input  logic signed [IN_W-1:0]    i_x,
  output logic signed [IN_W-1:0]    o_act,
  input  logic signed [IN_W-1:0]    i_satIn,
  output logic signed [OUT_W-1:0]   o_sat,
  output logic                      o_clamped
);

  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'(satMaxOf(OUT_W));
  localparam logic signed [IN_W-1:0] SAT_MIN = IN_W'(satMinOf(OUT_W));

  // Once x is known non-negative, the clip bound is compared as unsigned.
  always_comb begin
    o_act = i_x;
    case (i_mode)
      MODE_RELU: begin
        if (i_x[IN_W-1]) o_act = '0;
      end
      MODE_CLIP: begin
        if (i_x[IN_W-1])                o_act = '0;
        else if ($unsigned(i_x) > i_clip) o_act = i_clip;
      end
      MODE_LEAKY: begin
        if (i_x[IN_W-1]) o_act = i_x >>> i_shift;
      end
      default: o_act = i_x;
    endcase
  end

  always_comb begin
    o_sat     = i_satIn[OUT_W-1:0];
    o_clamped = 1'b0;
    if (i_satIn > SAT_MAX) begin
      o_sat     = SAT_MAX[OUT_W-1:0];
      o_clamped = 1'b1;
    end else if (i_satIn < SAT_MIN) begin
      o_sat     = SAT_MIN[OUT_W-1:0];
      o_clamped = 1'b1;
    end
  end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage valid/ready activation pipeline: stage 1 applies the activation,
// stage 2 saturates to OUT_W and tracks beats that needed clamping.
module activation_pipe
  import act_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int IN_W    = 32,
  parameter int OUT_W   = ACT_OUT_W,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cfg_valid_i,
  input  logic [1:0]               cfg_mode_i,
  input  logic [SHIFT_W-1:0]       cfg_shift_i,
  input  logic [IN_W-1:0]          cfg_clip_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [LANES*IN_W-1:0]    data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [LANES*OUT_W-1:0]   data_o,
  output logic [CNT_W-1:0]         sat_cnt_o,
  input  logic                     sat_clr_i
);

  localparam logic [IN_W-1:0]  CLIP_RST = IN_W'(satMaxOf(OUT_W));
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  act_mode_e                     r_mode;
  logic [SHIFT_W-1:0]            r_shift;
  logic [IN_W-1:0]               r_clip;
  logic                          r_s1Valid;
  logic                          r_s2Valid;
  logic                          r_s2Sat;
  logic [LANES-1:0][IN_W-1:0]    r_s1Data;
  logic [LANES-1:0][OUT_W-1:0]   r_s2Data;
  logic [CNT_W-1:0]              r_satCnt;
  logic [LANES-1:0][IN_W-1:0]    w_act;
  logic [LANES-1:0][OUT_W-1:0]   w_sat;
  logic [LANES-1:0]              w_clamped;
  logic                          w_adv1;
  logic                          w_adv2;

  // ready_i reaches ready_o combinationally so a full pipe keeps full throughput.
  assign w_adv2    = ~r_s2Valid | ready_i;
  assign w_adv1    = ~r_s1Valid | w_adv2;
  assign ready_o   = w_adv1;
  assign valid_o   = r_s2Valid;
  assign data_o    = r_s2Data;
  assign sat_cnt_o = r_satCnt;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    act_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .i_mode    (r_mode),
      .i_shift   (r_shift),
      .i_clip    (r_clip),
      .i_x       (data_i[k*IN_W +: IN_W]),
      .o_act     (w_act[k]),
      .i_satIn   (r_s1Data[k]),
      .o_sat     (w_sat[k]),
      .o_clamped (w_clamped[k])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mode  <= MODE_RELU;
      r_shift <= '0;
      r_clip  <= CLIP_RST;
    end else if (cfg_valid_i) begin
      r_mode  <= act_mode_e'(cfg_mode_i);
      r_shift <= cfg_shift_i;
      r_clip  <= cfg_clip_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
    end else if (valid_i && w_adv1) begin
      r_s1Valid <= 1'b1;
      r_s1Data  <= w_act;
    end else if (w_adv2) begin
      r_s1Valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s2Valid <= 1'b0;
      r_s2Data  <= '0;
      r_s2Sat   <= 1'b0;
    end else if (w_adv2) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Data <= w_sat;
        r_s2Sat  <= |w_clamped;
      end
    end
  end

  // Clear takes priority over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_satCnt <= '0;
    end else if (sat_clr_i) begin
      r_satCnt <= '0;
    end else if (r_s2Valid && ready_i && r_s2Sat && (r_satCnt != CNT_MAX)) begin
      r_satCnt <= r_satCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_activation_pipe.sv
// Directed bench for activation_pipe: a reference model fills a scoreboard queue
// on each accepted beat and every output transfer is popped and compared.
module tb_activation_pipe;

  localparam int LANES   = 4;
  localparam int IN_W    = 32;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;
  localparam int CNT_W   = 16;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic                     cfg_valid_i;
  logic [1:0]               cfg_mode_i;
  logic [SHIFT_W-1:0]       cfg_shift_i;
  logic [IN_W-1:0]          cfg_clip_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [LANES*IN_W-1:0]    data_i;
  logic                     valid_o;
  logic                     ready_i;
  logic [LANES*OUT_W-1:0]   data_o;
  logic [CNT_W-1:0]         sat_cnt_o;
  logic                     sat_clr_i;

  always #5 clk_i = ~clk_i;

  activation_pipe #(
    .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_mode_i(cfg_mode_i),
    .cfg_shift_i(cfg_shift_i), .cfg_clip_i(cfg_clip_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .sat_cnt_o(sat_cnt_o), .sat_clr_i(sat_clr_i)
  );

  typedef struct {
    logic [LANES*OUT_W-1:0] data;
    bit                     sat;
  } exp_t;

  exp_t        sbQueue[$];
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          mMode;
  int          mShift;
  logic [31:0] mClip;
  longint      mCnt;
  logic [31:0] lastOut;
  int          popCount;
  bit          lastAccepted;
  logic        lastReadyO;
  logic        lastValidO;
  logic [31:0] lastDataO;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] modelLane(input longint x, input int mode, input int shift,
                                           input logic [31:0] clip);
    longint y;
    longint c;
    c = longint'({32'h0, clip});
    case (mode)
      0:       y = x;
      1:       y = (x < 0) ? 0 : x;
      2:       y = (x < 0) ? 0 : ((x > c) ? c : x);
      default: y = (x < 0) ? (x >>> shift) : x;
    endcase
    if (y > 127)  return {1'b1, 8'h7f};
    if (y < -128) return {1'b1, 8'h80};
    return {1'b0, y[7:0]};
  endfunction

  function automatic exp_t modelBeat(input logic [127:0] d);
    exp_t       e;
    logic [8:0] r;
    longint     x;
    e.data = '0;
    e.sat  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      x = longint'($signed(d[k*32 +: 32]));
      r = modelLane(x, mMode, mShift, mClip);
      e.data[k*8 +: 8] = r[7:0];
      e.sat = e.sat | r[8];
    end
    return e;
  endfunction

  function automatic logic [127:0] packLanes(input int a0, input int a1, input int a2, input int a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic checkOutput(output bit satFlag);
    exp_t e;
    satFlag = 1'b0;
    checks++;
    assert (sbQueue.size() > 0) passes++;
    else begin
      fails++;
      $error("[TB] FAIL unexpected_beat observed=%0h expected=none", data_o);
    end
    if (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkEq("beat_data", 64'(data_o), 64'(e.data));
      satFlag = e.sat;
      lastOut = data_o;
      popCount++;
    end
  endtask

  // Inputs change 1 time unit after a rising edge; everything is sampled on the falling edge.
  task automatic applyStimulus(input bit v, input logic [127:0] d, input bit rdy,
                               input bit cfgV, input bit sclr);
    bit xfer;
    bit xferSat;
    valid_i     = v;
    data_i      = d;
    ready_i     = rdy;
    cfg_valid_i = cfgV;
    sat_clr_i   = sclr;
    @(negedge clk_i);
    lastReadyO = ready_o;
    lastValidO = valid_o;
    lastDataO  = data_o;
    xfer    = valid_o && ready_i;
    xferSat = 1'b0;
    if (xfer) checkOutput(xferSat);
    lastAccepted = v && ready_o;
    if (lastAccepted) sbQueue.push_back(modelBeat(d));
    if (cfgV) begin
      mMode  = int'(cfg_mode_i);
      mShift = int'(cfg_shift_i);
      mClip  = cfg_clip_i;
    end
    if (sclr) mCnt = 0;
    else if (xfer && xferSat && mCnt < 65535) mCnt++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic setCfg(input logic [1:0] mode, input logic [4:0] shift, input logic [31:0] clip);
    cfg_mode_i  = mode;
    cfg_shift_i = shift;
    cfg_clip_i  = clip;
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    int idx;
    int startPops;
    logic [127:0] bp [5];

    rst_i = 1'b1; cfg_valid_i = 0; cfg_mode_i = 0; cfg_shift_i = 0; cfg_clip_i = 0;
    valid_i = 0; data_i = '0; ready_i = 0; sat_clr_i = 0;
    mMode = 1; mShift = 0; mClip = 32'd127; mCnt = 0; popCount = 0; lastOut = '0;
    #12;
    checkEq("reset_valid_o", 64'(valid_o), 64'd0);
    checkEq("reset_ready_o", 64'(ready_o), 64'd1);
    checkEq("reset_data_o", 64'(data_o), 64'd0);
    checkEq("reset_sat_cnt", 64'(sat_cnt_o), 64'd0);
    #5 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    $display("[TB] ReLU with default configuration");
    applyStimulus(1'b1, packLanes(-5, 0, 100, 200), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkEq("relu_latency_valid", 64'(lastValidO), 64'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkEq("relu_latency_valid2", 64'(lastValidO), 64'd1);
    idle(1);
    checkEq("relu_data", 64'(lastOut), 64'h7f640000);
    checkEq("relu_sat_cnt", 64'(sat_cnt_o), 64'd1);

    $display("[TB] leaky ReLU, shift 2");
    setCfg(2'd3, 5'd2, 32'd0);
    applyStimulus(1'b1, packLanes(-8, -1, -1000, 40), 1'b1, 1'b0, 1'b0);
    idle(3);
    checkEq("leaky_data", 64'(lastOut), 64'h2880fffe);
    checkEq("leaky_sat_cnt", 64'(sat_cnt_o), 64'd2);

    $display("[TB] clipped ReLU, clip 6, and same-cycle reconfiguration");
    setCfg(2'd2, 5'd0, 32'd6);
    applyStimulus(1'b1, packLanes(-3, 3, 6, 7), 1'b1, 1'b0, 1'b0);
    idle(3);
    checkEq("clip_data", 64'(lastOut), 64'h06060300);
    checkEq("clip_sat_cnt", 64'(sat_cnt_o), 64'd2);
    cfg_mode_i = 2'd0;
    applyStimulus(1'b1, packLanes(-3, 3, 6, 7), 1'b1, 1'b1, 1'b0);
    idle(3);
    checkEq("cfg_same_cycle_old_mode", 64'(lastOut), 64'h06060300);
    applyStimulus(1'b1, packLanes(-3, 3, 6, 7), 1'b1, 1'b0, 1'b0);
    idle(3);
    checkEq("bypass_data", 64'(lastOut), 64'h070603fd);

    $display("[TB] backpressure with five beats");
    for (int i = 0; i < 5; i++) bp[i] = packLanes(10 + i, 11 + i, 12 + i, 13 + i);
    idx = 0;
    startPops = popCount;
    for (int cyc = 0; cyc < 20 && idx < 5; cyc++) begin
      applyStimulus(1'b1, bp[idx], (cyc >= 4), 1'b0, 1'b0);
      if (cyc == 2 || cyc == 3) begin
        checkEq("bp_ready_low", 64'(lastReadyO), 64'd0);
        checkEq("bp_valid_held", 64'(lastValidO), 64'd1);
        checkEq("bp_data_held", 64'(lastDataO), 64'h0d0c0b0a);
      end
      if (lastAccepted) idx++;
    end
    checkEq("bp_all_accepted", 64'(idx), 64'd5);
    idle(4);
    checkEq("bp_all_emerged", 64'(popCount - startPops), 64'd5);
    checkEq("bp_queue_empty", 64'(sbQueue.size()), 64'd0);

    $display("[TB] saturation counter ceiling and clear");
    setCfg(2'd0, 5'd0, 32'd0);
    for (int i = 0; i < 65539; i++)
      applyStimulus(1'b1, packLanes(1000, 1000, 1000, 1000), 1'b1, 1'b0, 1'b0);
    idle(3);
    checkEq("cnt_ceiling", 64'(sat_cnt_o), 64'hffff);
    checkEq("cnt_model", 64'(sat_cnt_o), 64'(mCnt));
    applyStimulus(1'b1, packLanes(1000, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, packLanes(1000, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, packLanes(1000, 0, 0, 0), 1'b1, 1'b0, 1'b1);
    checkEq("clr_xfer_valid", 64'(lastValidO), 64'd1);
    checkEq("clr_wins", 64'(sat_cnt_o), 64'd0);
    idle(3);
    checkEq("cnt_after_clr", 64'(sat_cnt_o), 64'(mCnt));

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1'b1, packLanes(1, 2, 3, 4), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, packLanes(5, 6, 7, 8), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, packLanes(9, 10, 11, 12), 1'b1, 1'b0, 1'b0);
    ready_i = 1'b0;
    valid_i = 1'b0;
    #1;
    checkEq("pre_rst_valid", 64'(valid_o), 64'd1);
    rst_i = 1'b1;
    #1;
    checkEq("rst_valid_o", 64'(valid_o), 64'd0);
    checkEq("rst_ready_o", 64'(ready_o), 64'd1);
    checkEq("rst_data_o", 64'(data_o), 64'd0);
    checkEq("rst_sat_cnt", 64'(sat_cnt_o), 64'd0);
    sbQueue.delete();
    mMode = 1; mShift = 0; mClip = 32'd127; mCnt = 0;
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkEq("post_rst_no_beat", 64'(lastValidO), 64'd0);
    end
    applyStimulus(1'b1, packLanes(-5, 0, 100, 200), 1'b1, 1'b0, 1'b0);
    idle(3);
    checkEq("post_rst_default_cfg", 64'(lastOut), 64'h7f640000);
    checkEq("post_rst_queue_empty", 64'(sbQueue.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/activation_pipe.md
Name: activation_pipe

Overview:
Multi-lane, mode-selectable activation stage placed between the systolic array's accumulator drain and the output buffer. Each beat carries LANES signed IN_W accumulators and leaves as LANES saturated signed OUT_W values. The block has two register stages with a valid/ready handshake, runtime mode configuration and a saturation event counter.

Parameters:
LANES, 4, number of parallel lanes per beat
IN_W, 32, signed input width per lane
OUT_W, 8, signed output width per lane (OUT_W <= IN_W)
SHIFT_W, 5, width of the leaky-ReLU shift amount
CNT_W, 16, width of the saturation counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
cfg_valid_i  in  1  write configuration registers this cycle
cfg_mode_i  in  2  0=bypass, 1=ReLU, 2=clipped ReLU, 3=leaky ReLU
cfg_shift_i  in  SHIFT_W  leaky right-shift amount
cfg_clip_i  in  IN_W  clipped-ReLU upper bound, unsigned
valid_i  in  1  input beat valid
ready_o  out  1  block accepts the beat
data_i  in  LANES*IN_W  lane k is at bits [k*IN_W +: IN_W], signed
valid_o  out  1  output beat valid
ready_i  in  1  downstream accepts the beat
data_o  out  LANES*OUT_W  lane k is at bits [k*OUT_W +: OUT_W], signed
sat_cnt_o  out  CNT_W  count of output beats with at least one saturated lane
sat_clr_i  in  1  synchronous clear of sat_cnt_o

Behaviour:
- Reset (async, active-high). All of the following take their reset values immediately:
  - s1_valid=0, s2_valid=0, all data registers 0
  - valid_o=0, data_o=0, sat_cnt_o=0
  - configuration: mode=1, shift=0, clip=2^(OUT_W-1)-1
  - ready_o is 1 after reset, because the pipe is empty.
- Configuration:
  - When cfg_valid_i=1 at a clock edge, the config registers load.
  - A beat accepted in that same cycle uses the old config. Beats accepted from the next cycle onward use the new config.
  - In-flight beats are never affected.
- Handshake:
  - A transfer occurs when valid and ready are both high.
  - adv2 = ~s2_valid | ready_i.
  - adv1 = ~s1_valid | adv2.
  - ready_o = adv1. This is a combinational path from ready_i to ready_o and is intentional.
  - valid_o = s2_valid. data_o and valid_o are held stable while valid_o=1 and ready_i=0.
- Stage 1 (loads on valid_i & ready_o): registers the per-lane activation of data_i.
  - bypass: y = x
  - ReLU: y = (x<0) ? 0 : x
  - clipped ReLU: y = (x<0) ? 0 : min(x, clip). The comparison is unsigned against clip once x>=0.
  - leaky ReLU: y = (x<0) ? (x >>> shift) : x. The shift is arithmetic and rounds toward -inf, so -1 >>> n = -1.
- Stage 2 (loads on adv2 & s1_valid): per-lane signed saturation to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Stage 2 also registers a sat flag: OR over lanes of "clamped".
  - s1_valid clears when stage 1 is drained and no new beat arrives.
- Latency: 2 cycles from input transfer to valid_o when there is no backpressure. Throughput is 1 beat per cycle.
- Full pipe: both stages valid and ready_i=0 gives ready_o=0, and nothing moves. Releasing ready_i gives full throughput the same cycle.
- Counter:
  - Increments by 1 on each output transfer whose sat flag=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - sat_clr_i together with an increment: the clear wins and the result is 0.
- Reset mid-operation discards all in-flight beats. No output transfer occurs for them.

Decomposition:
- Package act_pkg holds:
  - the act_mode_e enum (MODE_BYPASS, MODE_RELU, MODE_CLIP, MODE_LEAKY)
  - localparams for saturation bounds derived from OUT_W
- Sub-module act_lane: purely combinational per-lane activation plus saturation helper, instantiated LANES times per stage via generate.
- Pipeline registers, handshake and counter live in activation_pipe.

Test Plan:
1. Reset, then mode=ReLU with lanes {-5, 0, 100, 200} and ready_i=1 -> 2 cycles later data_o lanes {0, 0, 100, 127}, sat_cnt_o=1.
2. Set mode=leaky, shift=2, with lanes {-8, -1, -1000, 40} -> {-2, -1, -128, 40}. The -1000 lane (-250) clamps, so the sat flag is set.
3. Set mode=clip, clip=6, with lanes {-3, 3, 6, 7} -> {0, 3, 6, 6}, sat flag=0. Also issue cfg_valid_i in the same cycle as a beat and check that the beat uses the old mode.
4. Backpressure: stream 5 beats with ready_i=0 for 4 cycles -> ready_o drops after 2 beats are accepted, data_o stays stable, then all 5 beats emerge in order with none lost or duplicated.
5. Counter: force 2^16+3 saturating beats -> sat_cnt_o=0xFFFF. Assert sat_clr_i together with a saturating transfer -> sat_cnt_o=0.
6. Assert rst_i asynchronously mid-stream -> valid_o=0 and ready_o=1 immediately, with no stale beat after release.
